// File: rtl/adder_driver.sv
// -----------------------------------------------------------------------------
// adder_driver
//
// Request-side driver for the sequential adder's start/ready operand interface.
// It produces operand pairs, either from two free-running Galois LFSRs or from
// external inputs. Each pair is issued with a one-cycle start pulse. The driver
// then waits for the adder's ready pulse and compares res/overflow against a
// golden (WIDTH+1)-bit sum. Passes and errors are counted, and sim_over_o is
// raised once NUM_TXN transactions have retired.
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   go_i           level; sampled high in idle starts a run
//   ext_en_i       1: operands from ext_a_i/ext_b_i, 0: from the LFSRs
//   ext_a_i        external operand A
//   ext_b_i        external operand B
//   a_o, b_o       operands to the adder, held from start until retire
//   start_o        one-cycle request pulse
//   ready_i        one-cycle completion pulse from the adder
//   res_i          adder sum, valid with ready_i
//   overflow_i     adder carry-out, valid with ready_i
//   busy_o         high while issuing or waiting
//   sim_over_o     run complete, held until reset
//   pass_cnt_o     transactions that matched (saturating)
//   err_cnt_o      mismatches plus timeouts (saturating)
//   timeout_err_o  sticky, some transaction timed out
//   spurious_err_o sticky, ready seen outside the wait state
// -----------------------------------------------------------------------------
module adder_driver #(
   parameter int          WIDTH   = 32,
   parameter int          NUM_TXN = 16,
   parameter logic [31:0] SEED    = 32'h0000_0001,
   parameter int          TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             go_i,
   input  logic             ext_en_i,
   input  logic [WIDTH-1:0] ext_a_i,
   input  logic [WIDTH-1:0] ext_b_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             start_o,
   input  logic             ready_i,
   input  logic [WIDTH-1:0] res_i,
   input  logic             overflow_i,
   output logic             busy_o,
   output logic             sim_over_o,
   output logic [15:0]      pass_cnt_o,
   output logic [15:0]      err_cnt_o,
   output logic             timeout_err_o,
   output logic             spurious_err_o
);

   // Galois tap mask for x^32 + x^22 + x^2 + x + 1 when shifting right.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [31:0] SEED_A    = SEED;
   localparam logic [31:0] SEED_B    = ~SEED;

   // The counter widths are sized so that the compare constants fit.
   localparam int TXN_W  = (NUM_TXN > 1) ? $clog2(NUM_TXN + 1) : 1;
   localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDone  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [31:0]       lfsr_a_q, lfsr_a_d;
   logic [31:0]       lfsr_b_q, lfsr_b_d;
   logic [15:0]       pass_q, pass_d;
   logic [15:0]       err_q, err_d;
   logic [TXN_W-1:0]  txn_q, txn_d;
   logic [WCNT_W-1:0] wait_q, wait_d;
   logic              timeout_q, timeout_d;
   logic              spurious_q, spurious_d;

   logic [WIDTH:0]    expected;
   logic              match;
   logic              timedOut;
   logic              retire;
   logic [TXN_W-1:0]  txnNext;
   logic              lastTxn;

   // One right shift of a Galois LFSR: the bit shifted out folds the taps back in.
   function automatic logic [31:0] lfsrStep(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] satInc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // The golden sum is computed from the held operands. A transaction retires
   // on ready or on the last allowed wait cycle. Ready takes priority over
   // timeout when both occur in the same cycle.
   always_comb begin
      expected = {1'b0, a_q} + {1'b0, b_q};
      match    = (res_i == expected[WIDTH-1:0]) && (overflow_i == expected[WIDTH]);
      timedOut = !ready_i && (wait_q == WCNT_W'(TIMEOUT - 1));
      retire   = (state_q == StWait) && (ready_i || timedOut);
      txnNext  = txn_q + TXN_W'(1);
      lastTxn  = (txnNext == TXN_W'(NUM_TXN));
   end

   // State register, operand and counter registers. A reset mid-run aborts
   // immediately and leaves nothing of the previous run behind.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         lfsr_a_q   <= SEED_A;
         lfsr_b_q   <= SEED_B;
         pass_q     <= '0;
         err_q      <= '0;
         txn_q      <= '0;
         wait_q     <= '0;
         timeout_q  <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         lfsr_a_q   <= lfsr_a_d;
         lfsr_b_q   <= lfsr_b_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         txn_q      <= txn_d;
         wait_q     <= wait_d;
         timeout_q  <= timeout_d;
         spurious_q <= spurious_d;
      end
   end

   // Next-state logic. Once a run starts, go is ignored. Done is left only
   // through reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (go_i) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            if (retire) begin
               state_d = lastTxn ? StDone : StIssue;
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Datapath next values.
   // Operands load on the edge that enters issue, so they are already valid
   // while start is high. They then stay put until the transaction retires.
   // Both LFSRs step on every issue cycle, whatever the operand source, so the
   // LFSR sequence does not depend on ext_en.
   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      lfsr_a_d   = lfsr_a_q;
      lfsr_b_d   = lfsr_b_q;
      pass_d     = pass_q;
      err_d      = err_q;
      txn_d      = txn_q;
      wait_d     = wait_q;
      timeout_d  = timeout_q;
      spurious_d = spurious_q;

      if (state_d == StIssue) begin
         if (ext_en_i) begin
            a_d = ext_a_i;
            b_d = ext_b_i;
         end else begin
            a_d = WIDTH'(lfsr_a_q);
            b_d = WIDTH'(lfsr_b_q);
         end
      end

      if (state_q == StIssue) begin
         lfsr_a_d = lfsrStep(lfsr_a_q);
         lfsr_b_d = lfsrStep(lfsr_b_q);
         wait_d   = '0;
      end

      if (state_q == StWait) begin
         wait_d = wait_q + WCNT_W'(1);
         if (ready_i) begin
            if (match) begin
               pass_d = satInc(pass_q);
            end else begin
               err_d = satInc(err_q);
            end
         end else if (timedOut) begin
            err_d     = satInc(err_q);
            timeout_d = 1'b1;
         end
         if (retire) begin
            txn_d = txnNext;
         end
      end

      // A ready pulse is only legal while a request is outstanding.
      if (ready_i && (state_q != StWait)) begin
         spurious_d = 1'b1;
      end
   end

   // Output decode. Handshake and status flags come straight from the state,
   // so they all clear asynchronously with reset.
   always_comb begin
      start_o        = (state_q == StIssue);
      busy_o         = (state_q == StIssue) || (state_q == StWait);
      sim_over_o     = (state_q == StDone);
      a_o            = a_q;
      b_o            = b_q;
      pass_cnt_o     = pass_q;
      err_cnt_o      = err_q;
      timeout_err_o  = timeout_q;
      spurious_err_o = spurious_q;
   end

endmodule
